// File: rtl/fixed_point_div_pkg.sv
`default_nettype none
// ============================================================================
// Package   : fixed_point_div_pkg
// Purpose   : Shared types and derived constants for the sequential
//             fixed-point divider.
//             - FSM state type
//             - iteration count
//             - numerator alignment shift
//             - saturation limits
// Contents  : state_t, calc_nit(), calc_shift(), sat_limit_pos(),
//             sat_limit_neg()
// Revision  : 1.0 - initial release
// ============================================================================
package fixed_point_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Produces one quotient bit per iteration. The last bit is a guard bit
  // that sits below the output LSB.
  function automatic int calc_nit(input int wiia, input int wifb, input int wof);
    return wiia + wifb + wof + 1;
  endfunction

  // Left shift of |ina|. It places the dividend so that the quotient lands in
  // units of 2^-(WOF+1).
  function automatic int calc_shift(input int wifa, input int wifb, input int wof);
    return wifb + wof + 1 - wifa;
  endfunction

  // Largest magnitude a positive result may have.
  function automatic longint sat_limit_pos(input int woi, input int wof);
    return (longint'(1) << (woi + wof - 1)) - longint'(1);
  endfunction

  // Largest magnitude a negative result may have. This is one more than the
  // positive limit because two's complement is asymmetric.
  function automatic longint sat_limit_neg(input int woi, input int wof);
    return longint'(1) << (woi + wof - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_point_div_finalize.sv
`default_nettype none
// ============================================================================
// Module    : fixed_point_div_finalize
// Purpose   : Combinational post-processing of the raw unsigned quotient:
//             - drops the guard bit, optionally rounding half away from zero
//             - applies the result sign
//             - saturates on overflow
//             - forces the divide-by-zero result
// Ports     : q        [NIT-1:0]     in  raw quotient with one guard bit
//             sign     1             in  result is negative
//             zero     1             in  divisor was zero
//             out      [WOI+WOF-1:0] out signed quotient
//             overflow 1             out saturated or divide by zero
// Revision  : 1.0 - initial release
// ============================================================================
module fixed_point_div_finalize
  import fixed_point_div_pkg::*;
#(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int NIT   = 25,
  parameter int ROUND = 1
) (
  input  logic [NIT-1:0]     q,
  input  logic               sign,
  input  logic               zero,
  output logic [WOI+WOF-1:0] out,
  output logic               overflow
);

  localparam int WO = WOI + WOF;
  // Wide enough for the magnitude, the limits, and a possible rounding carry.
  localparam int CW = ((NIT > WO) ? NIT : WO) + 1;

  localparam logic [CW-1:0] LIM_POS = CW'(sat_limit_pos(WOI, WOF));
  localparam logic [CW-1:0] LIM_NEG = CW'(sat_limit_neg(WOI, WOF));
  localparam logic [WO-1:0] MAX_POS = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MIN_NEG = {1'b1, {(WO-1){1'b0}}};

  logic          rnd_bit;
  logic [CW-1:0] mag;

  // The guard bit equals the half-LSB. Adding it to the truncated magnitude
  // rounds half away from zero, because the sign is applied afterwards.
  generate
    if (ROUND != 0) begin : g_round
      assign rnd_bit = q[0];
    end else begin : g_trunc
      assign rnd_bit = 1'b0;
    end
  endgenerate

  assign mag = CW'(q >> 1) + CW'(rnd_bit);

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    if (zero) begin
      // The divisor is zero, so its sign bit is clear and sign equals sign(ina).
      overflow = 1'b1;
      out      = sign ? MIN_NEG : MAX_POS;
    end else if (sign && (mag > LIM_NEG)) begin
      overflow = 1'b1;
      out      = MIN_NEG;
    end else if (!sign && (mag > LIM_POS)) begin
      overflow = 1'b1;
      out      = MAX_POS;
    end else begin
      out = sign ? WO'(~mag + CW'(1)) : WO'(mag);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_fixed_point_div.sv
`default_nettype none
// ============================================================================
// Module    : seq_fixed_point_div
// Purpose   : Multi-cycle signed fixed-point divider, out = ina / inb.
//             - restoring shift-subtract, one quotient bit per clock
//             - valid/ready handshake on both sides
//             - saturates on overflow and on divide by zero
// Ports     : clk       1              in  clock
//             rst       1              in  synchronous active-high reset
//             in_valid  1              in  operands valid
//             in_ready  1              out block can accept operands
//             ina       [WIIA+WIFA-1:0] in signed dividend
//             inb       [WIIB+WIFB-1:0] in signed divisor
//             out_valid 1              out result valid
//             out_ready 1              in  consumer takes result
//             out       [WOI+WOF-1:0]  out signed quotient
//             overflow  1              out result saturated or divide by zero
// Revision  : 1.0 - initial release
// ============================================================================
module seq_fixed_point_div
  import fixed_point_div_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIIA+WIFA-1:0] ina,
  input  logic [WIIB+WIFB-1:0] inb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WOI+WOF-1:0]   out,
  output logic                 overflow
);

  localparam int WA   = WIIA + WIFA;
  localparam int WB   = WIIB + WIFB;
  localparam int WO   = WOI + WOF;
  localparam int NIT  = calc_nit(WIIA, WIFB, WOF);
  localparam int S    = calc_shift(WIFA, WIFB, WOF);
  localparam int CNTW = $clog2(NIT + 1);

  state_t state, state_next;

  logic            accept;
  logic [WA-1:0]   mag_a;
  logic [WB-1:0]   mag_b;

  logic [NIT-1:0]  num;      // aligned numerator, consumed MSB first
  logic [WB:0]     rem;      // partial remainder
  logic [WB-1:0]   dvs;      // divisor magnitude
  logic [NIT-1:0]  quo;      // quotient including the guard bit
  logic [CNTW-1:0] cnt;
  logic            sign;
  logic            zero;

  logic [WB:0]     rem_shift;
  logic            rem_ge;
  logic [WB:0]     rem_sub;
  logic            last_iter;

  logic [WO-1:0]   fin_out;
  logic            fin_ovf;
  logic [WO-1:0]   out_r;
  logic            ovf_r;

  // Two's-complement negation of the most negative value gives that same bit
  // pattern. Read as unsigned, that pattern is the correct magnitude, so no
  // extra bit is needed.
  assign mag_a = ina[WA-1] ? ((~ina) + WA'(1)) : ina;
  assign mag_b = inb[WB-1] ? ((~inb) + WB'(1)) : inb;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_iter) state_next = FIX;
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  // Shift the remainder left and bring in the next numerator bit. The
  // stored remainder is always smaller than the divisor, so its top bit is
  // zero. Truncating after the shift therefore loses nothing.
  assign rem_shift = (WB+1)'({rem, num[NIT-1]});
  assign rem_ge    = rem_shift >= {1'b0, dvs};
  assign rem_sub   = rem_shift - {1'b0, dvs};
  assign last_iter = (cnt == CNTW'(NIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      num   <= '0;
      rem   <= '0;
      dvs   <= '0;
      quo   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      zero  <= 1'b0;
      out_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (accept) begin
        num  <= NIT'(mag_a) << S;
        rem  <= '0;
        dvs  <= mag_b;
        quo  <= '0;
        cnt  <= '0;
        sign <= ina[WA-1] ^ inb[WB-1];
        zero <= (inb == '0);
      end else if (state == CALC) begin
        num <= num << 1;
        cnt <= cnt + CNTW'(1);
        quo <= {quo[NIT-2:0], rem_ge};
        if (rem_ge) rem <= rem_sub;
        else        rem <= rem_shift;
      end else if (state == FIX) begin
        out_r <= fin_out;
        ovf_r <= fin_ovf;
      end
    end
  end

  fixed_point_div_finalize #(
    .WOI   (WOI),
    .WOF   (WOF),
    .NIT   (NIT),
    .ROUND (ROUND)
  ) u_finalize (
    .q        (quo),
    .sign     (sign),
    .zero     (zero),
    .out      (fin_out),
    .overflow (fin_ovf)
  );

  assign out      = out_r;
  assign overflow = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_seq_fixed_point_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module    : tb_seq_fixed_point_div
// Purpose   : Self-checking bench for seq_fixed_point_div.
//             - drives a ROUND=1 and a ROUND=0 instance in lockstep
//             - checks both against an arithmetic reference model
// Revision  : 1.0 - initial release
// ============================================================================
module tb_seq_fixed_point_div;

  localparam int LAT = 26;  // accept edge to out_valid edge at defaults

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] ina = '0;
  logic [15:0] inb = '0;

  logic        in_ready1, out_valid1, ovf1;
  logic [15:0] out1;
  logic        in_ready0, out_valid0, ovf0;
  logic [15:0] out0;

  int tests = 0;
  int fails = 0;

  logic        exp_act = 1'b0;
  logic [15:0] exp_a, exp_b;
  logic [15:0] exp1, exp0;
  logic        eov1, eov0;

  always #5 clk = ~clk;

  seq_fixed_point_div #(.ROUND(1)) dut_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .ina(ina), .inb(inb), .out_valid(out_valid1), .out_ready(out_ready),
    .out(out1), .overflow(ovf1)
  );

  seq_fixed_point_div #(.ROUND(0)) dut_r0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .ina(ina), .inb(inb), .out_valid(out_valid0), .out_ready(out_ready),
    .out(out0), .overflow(ovf0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: the exact quotient a/b in Q8.8. Both operands have 8 fraction
  // bits, so the result magnitude is |a|*256/|b| in output LSBs. With rounding
  // enabled the model computes floor(x + 1/2). After that it applies the sign,
  // then saturates.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input bit rnd,
                                output logic [15:0] o, output logic ov);
    longint sa, sb, ma, mb, m, lim;
    bit neg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      ov = 1'b1;
      o  = (sa < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
      neg = (sa < 0) != (sb < 0);
      if (rnd) m = (ma * 512 + mb) / (2 * mb);
      else     m = (ma * 256) / mb;
      lim = neg ? 32768 : 32767;
      if (m > lim) begin
        ov = 1'b1;
        o  = neg ? 16'h8000 : 16'h7FFF;
      end else begin
        ov = 1'b0;
        o  = neg ? 16'(-m) : 16'(m);
      end
    end
  endfunction

  // Whenever a result is presented, it must match the model and the block
  // must stay busy.
  always @(negedge clk) begin
    if (exp_act && out_valid1) begin
      tests++;
      if (out1 !== exp1 || ovf1 !== eov1) begin
        fails++;
        $display("FAIL result_round a=%h b=%h out=%h ovf=%b expected out=%h ovf=%b",
                 exp_a, exp_b, out1, ovf1, exp1, eov1);
      end
      tests++;
      if (out0 !== exp0 || ovf0 !== eov0) begin
        fails++;
        $display("FAIL result_trunc a=%h b=%h out=%h ovf=%b expected out=%h ovf=%b",
                 exp_a, exp_b, out0, ovf0, exp0, eov0);
      end
      tests++;
      if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
        fails++;
        $display("FAIL busy_in_done in_ready=%b/%b out_valid0=%b expected 0/0/1",
                 in_ready1, in_ready0, out_valid0);
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        input bit has_lit, input logic [15:0] l1, input logic [15:0] l0,
                        input logic lov);
    logic [15:0] e1, e0;
    logic        v1, v0;
    int          n;
    model(a, b, 1'b1, e1, v1);
    model(a, b, 1'b0, e0, v0);
    if (has_lit) begin
      check("model_round", {16'h0, e1}, {16'h0, l1});
      check("model_trunc", {16'h0, e0}, {16'h0, l0});
      check("model_ovf",   {31'h0, v1}, {31'h0, lov});
    end
    n = 0;
    while (!in_ready1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_op", {31'h0, in_ready1}, 32'h1);
    exp_a = a; exp_b = b;
    exp1 = e1; eov1 = v1; exp0 = e0; eov0 = v0;
    exp_act = 1'b1;
    ina = a; inb = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ina = 16'($urandom);
    inb = 16'($urandom);
    n = 0;
    while (!out_valid1 && n < LAT + 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, LAT);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      ina = 16'($urandom);
      inb = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", {31'h0, out_valid1}, 32'h1);
      check("hold_ready", {31'h0, in_ready1}, 32'h0);
    end
    // Keep a request pending across the handshake edge. It must not be taken.
    in_valid  = (hold > 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_act   = 1'b0;
    check("valid_drop", {31'h0, out_valid1}, 32'h0);
    check("ready_back", {31'h0, in_ready1}, 32'h1);
  endtask

  logic [15:0] ta  [9] = '{16'h0300, 16'h0200, 16'hFF00, 16'h0100, 16'h6400,
                           16'h8000, 16'hFE00, 16'h0000, 16'h8000};
  logic [15:0] tb_ [9] = '{16'h0200, 16'h0300, 16'h0300, 16'h0003, 16'h0080,
                           16'hFF00, 16'h0000, 16'h0000, 16'h0100};
  logic [15:0] t1  [9] = '{16'h0180, 16'h00AB, 16'hFFAB, 16'h5555, 16'h7FFF,
                           16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
  logic [15:0] t0  [9] = '{16'h0180, 16'h00AA, 16'hFFAB, 16'h5555, 16'h7FFF,
                           16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
  logic        tov [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {31'h0, in_ready1},  32'h1);
    check("reset_out_valid", {31'h0, out_valid1}, 32'h0);
    check("reset_out",       {16'h0, out1},       32'h0);
    check("reset_overflow",  {31'h0, ovf1},       32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op(ta[i], tb_[i], (i == 0) ? 5 : 0, 1'b1, t1[i], t0[i], tov[i]);

    // Abandon an operation part-way through CALC.
    ina = 16'h0300; inb = 16'h0200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", {31'h0, out_valid1}, 32'h0);
    check("midrst_in_ready",  {31'h0, in_ready1},  32'h1);
    check("midrst_out",       {16'h0, out1},       32'h0);
    check("midrst_overflow",  {31'h0, ovf1},       32'h0);
    run_op(16'h0300, 16'h0200, 0, 1'b1, 16'h0180, 16'h0180, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      if (i % 4 == 0)      rb = 16'($urandom_range(0, 7));
      else if (i % 4 == 1) rb = 16'($urandom) | 16'h0100;
      else                 rb = 16'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 2)), 1'b0, 16'h0, 16'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
